// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold-time limit.
// Registered one-hot and encoded grant outputs.
module bus_arbiter #(
   parameter int SIZE     = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_n,
   input  logic [SIZE-1:0]         i_Req,
   input  logic                    i_Disable,
   output logic [SIZE-1:0]         o_Grant,
   output logic [$clog2(SIZE)-1:0] o_Grant_Idx,
   output logic                    o_Busy,
   output logic                    o_Timeout
);

   localparam int IW = $clog2(SIZE);
   localparam int CW = $clog2(MAX_HOLD + 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE-1:0] grant_d;
   logic [IW-1:0]   idx_d;
   logic            busy_d;
   logic            tmo_d;

   logic            found;
   logic [IW-1:0]   win;
   logic [IW-1:0]   win_nxt;
   int              pos;

   // Search upward from ptr, wrapping at SIZE (works for any SIZE).
   always_comb begin
      found = 1'b0;
      win   = '0;
      pos   = 0;
      for (int i = 0; i < SIZE; i++) begin
         pos = int'(ptr_q) + i;
         if (pos >= SIZE)
            pos = pos - SIZE;
         if (!found && i_Req[pos]) begin
            found = 1'b1;
            win   = IW'(pos);
         end
      end
   end

   assign win_nxt = (int'(win) == SIZE - 1) ? '0 : win + IW'(1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = o_Grant;
      idx_d   = o_Grant_Idx;
      busy_d  = o_Busy;
      tmo_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!i_Disable && found) begin
               state_d = GRANT;
               idx_d   = win;
               grant_d = SIZE'(1) << win;
               busy_d  = 1'b1;
               cnt_d   = CW'(1);
               ptr_d   = win_nxt;
            end
         end
         GRANT: begin
            if (!i_Req[o_Grant_Idx]) begin
               state_d = IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
            end else if (cnt_q == CW'(MAX_HOLD)) begin
               state_d = IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         o_Grant     <= '0;
         o_Grant_Idx <= '0;
         o_Busy      <= 1'b0;
         o_Timeout   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         o_Grant     <= grant_d;
         o_Grant_Idx <= idx_d;
         o_Busy      <= busy_d;
         o_Timeout   <= tmo_d;
      end
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares a single bus resource (e.g. the memory bus among CPU, DMA and PPU) between up to SIZE requesters. It picks one requester, holds the grant until the requester releases it or a hold-time limit expires, then rotates priority. The grant is presented both as an encoded index and as a one-hot vector, with an all-zero vector when the bus is idle. That one-hot vector drives the downstream bus-select logic.

## Interface
- SIZE, 8, number of requesters; SIZE ≥ 2.
- MAX_HOLD, 16, maximum consecutive cycles one grant may last; MAX_HOLD ≥ 2.

- i_Clk  input  1  clock; all state changes on the rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Req  input  SIZE  request vector; bit n high means requester n wants the bus, or still holds it.
- i_Disable  input  1  when high, blocks new grants; does not revoke the current grant.
- o_Grant  output  SIZE  one-hot grant; all zeros when o_Busy is low.
- o_Grant_Idx  output  $clog2(SIZE)  index of the current or most recent owner.
- o_Busy  output  1  high while a grant is active.
- o_Timeout  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

## Operation
- **Registers**
  - State: IDLE or GRANT.
  - Rotating priority pointer ptr, width $clog2(SIZE).
  - Hold counter cnt, width $clog2(MAX_HOLD+1).
  - All outputs are registered.
- **Reset** (asynchronous, takes effect immediately without a clock edge)
  - State = IDLE, ptr = 0, cnt = 0.
  - o_Grant = 0, o_Grant_Idx = 0, o_Busy = 0, o_Timeout = 0.
  - A reset during an active grant drops the grant immediately.
- **IDLE**
  - If i_Disable = 0 and i_Req ≠ 0, the winner is the first set bit at or after ptr, searching upward and wrapping from SIZE-1 to 0.
  - Next edge: state = GRANT, o_Grant_Idx = winner, o_Grant = 1 << winner, o_Busy = 1, cnt = 1.
  - Next edge also sets ptr = winner+1, wrapping SIZE-1 → 0. This must hold for non-power-of-2 SIZE.
  - If i_Disable = 1 or i_Req = 0, stay in IDLE with all outputs unchanged.
- **GRANT**, evaluated on each edge in this priority order:
  - If i_Req[o_Grant_Idx] = 0: release. State = IDLE, o_Grant = 0, o_Busy = 0.
  - Else if cnt = MAX_HOLD: forced release. State = IDLE, o_Grant = 0, o_Busy = 0, o_Timeout = 1.
  - Else: cnt = cnt+1 and the grant is held.
  - Requests on other lines are ignored while in GRANT.
- **o_Timeout**: high for exactly the one cycle after a forced release; 0 otherwise.
- **o_Grant_Idx** keeps the last owner's index while in IDLE.
- **o_Grant** is always zero or exactly one-hot, and always equals (o_Busy ? 1 << o_Grant_Idx : 0).
- **Fairness**: ptr moves past each winner. A requester that keeps requesting is therefore served at least once every SIZE grants.

## Timing
- Request-to-grant latency: 1 cycle. A request sampled in IDLE at edge k gives o_Grant valid after edge k.
- Release latency: 1 cycle. i_Req[owner] low at edge k gives o_Grant = 0 after edge k.
- Every grant is followed by at least one IDLE cycle. Back-to-back ownership therefore has a 1-cycle gap on o_Busy.
- Maximum grant length is MAX_HOLD cycles of o_Busy high. The re-grant cycle is:
  - cycles of o_Busy high for a persistent sole requester: MAX_HOLD
  - cycles of o_Busy low between its grants: 1
  - total period: MAX_HOLD+1
- Simultaneous release and timeout on the same edge count as a normal release: o_Timeout stays 0.
- i_Disable rising during GRANT takes effect at the next arbitration in IDLE.
- i_Disable falling in IDLE with requests pending gives a grant on the next edge.

## Test plan
- **Basic grant and handoff**
  - Stimulus: reset, then i_Req = 8'h05.
  - Required: after 1 edge, o_Grant = 8'h01, o_Grant_Idx = 0, o_Busy = 1.
  - Stimulus: drop i_Req[0].
  - Required: 1 cycle of o_Grant = 0, then o_Grant = 8'h04, o_Grant_Idx = 2.
- **Rotation**
  - Stimulus: i_Req = 8'hFF, each owner deasserts its bit after 2 granted cycles and reasserts it later.
  - Required: grant order is 0,1,2,…,7,0.
- **Timeout**
  - Stimulus: i_Req = 8'h08 held constant.
  - Required: o_Grant = 8'h08 for exactly 16 cycles, then o_Timeout = 1 for 1 cycle with o_Busy = 0, then grant 8'h08 again.
- **Wrap-around**
  - Stimulus: after granting index 6 (ptr = 7), set i_Req = 8'h81.
  - Required: grant 7 first, then grant 0 after 7 releases.
- **Disable**
  - Stimulus: i_Disable = 1 with i_Req = 8'h10.
  - Required: o_Busy stays 0.
  - Stimulus: i_Disable asserted during an active grant.
  - Required: the grant runs to its release, then no new grant while i_Disable is high.
- **Async reset mid-grant**
  - Stimulus: pull i_Rst_n low between clock edges while o_Busy = 1.
  - Required: all outputs go to 0 immediately.
  - Stimulus: after release, i_Req = 8'hFF.
  - Required: index 0 is granted first.
